cam_rgb565_capture: RTL

// Upstream stage of the luma path. Captures the 8-bit DVP camera stream
// (vsync/href/data, sampled on the camera pixel clock) and assembles byte

---
 rtl/cam_rgb565_capture.sv | 252 +++++++++++++++++++++++++
 1 files changed

// File: rtl/cam_rgb565_capture.sv
// -----------------------------------------------------------------------------
// cam_rgb565_capture
// Captures an 8-bit DVP camera stream and assembles byte pairs into RGB565
// pixels for the downstream RGB565->Y converter. After reset a number of
// settle frames are discarded. Lines with a dangling half pixel or more than
// H_ACTIVE pixels raise a one-cycle line_err pulse.
//
// Ports
//   clk          camera PCLK, all logic on the rising edge
//   rst_n        synchronous reset, active low
//   cam_vsync    frame sync, high = vertical blanking
//   cam_href     line valid, high = active byte on cam_data
//   cam_data     pixel byte
//   rgb_out      assembled RGB565 pixel, holds its value between strobes
//   rgb_valid    one-cycle strobe qualifying rgb_out/pix_x/pix_y
//   pix_x        column of the emitted pixel
//   pix_y        row of the emitted pixel
//   frame_start  one-cycle pulse when a captured frame begins
//   frame_done   one-cycle pulse when a captured frame ends
//   line_err     one-cycle pulse for an odd byte count or an overlong line
// -----------------------------------------------------------------------------
module cam_rgb565_capture #(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int SKIP_FRAMES = 10,
    parameter int HI_FIRST    = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cam_vsync,
    input  logic        cam_href,
    input  logic [7:0]  cam_data,
    output logic [15:0] rgb_out,
    output logic        rgb_valid,
    output logic [10:0] pix_x,
    output logic [10:0] pix_y,
    output logic        frame_start,
    output logic        frame_done,
    output logic        line_err
);

    typedef enum logic [1:0] {
        ST_SKIP   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_ACTIVE = 2'd2
    } state_t;

    localparam int              SKW      = (SKIP_FRAMES > 0) ? $clog2(SKIP_FRAMES + 1) : 1;
    localparam logic [SKW-1:0]  SKIP_LIM = SKW'(SKIP_FRAMES);
    localparam logic [10:0]     H_LIM    = 11'(H_ACTIVE);
    localparam logic [10:0]     V_LIM    = 11'(V_ACTIVE);
    localparam state_t          ST_INIT  = (SKIP_FRAMES == 0) ? ST_ARMED : ST_SKIP;

    // Input stage and one extra delay for edge detection
    logic           v1_r, h1_r, v2_r, h2_r;
    logic [7:0]     d1_r;

    // Control and datapath state
    state_t         state_r, state_nxt_s;
    logic [SKW-1:0] skip_cnt_r, skip_cnt_nxt_s;
    logic           phase_r, phase_nxt_s;
    logic [7:0]     first_r, first_nxt_s;
    logic [10:0]    x_r, x_nxt_s;
    logic [10:0]    y_r, y_nxt_s;
    logic           ovf_r, ovf_nxt_s;

    // Registered outputs
    logic [15:0]    rgb_out_r, rgb_out_nxt_s;
    logic           rgb_valid_r, rgb_valid_nxt_s;
    logic [10:0]    pix_x_r, pix_x_nxt_s;
    logic [10:0]    pix_y_r, pix_y_nxt_s;
    logic           frame_start_r, frame_start_nxt_s;
    logic           frame_done_r, frame_done_nxt_s;
    logic           line_err_r, line_err_nxt_s;

    logic           vs_fall_s, vs_rise_s, hs_fall_s;
    logic [15:0]    pixel_s;
    logic           y_in_s;

    assign vs_fall_s = v2_r & ~v1_r;
    assign vs_rise_s = ~v2_r & v1_r;
    assign hs_fall_s = h2_r & ~h1_r;
    assign pixel_s   = (HI_FIRST != 0) ? {first_r, d1_r} : {d1_r, first_r};
    // Rows past V_ACTIVE are silently dropped, including their errors
    assign y_in_s    = (y_r < V_LIM);

    assign rgb_out     = rgb_out_r;
    assign rgb_valid   = rgb_valid_r;
    assign pix_x       = pix_x_r;
    assign pix_y       = pix_y_r;
    assign frame_start = frame_start_r;
    assign frame_done  = frame_done_r;
    assign line_err    = line_err_r;

    // Register the camera pins; every decision uses these copies
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1_r <= 1'b0;
            h1_r <= 1'b0;
            v2_r <= 1'b0;
            h2_r <= 1'b0;
            d1_r <= 8'h00;
        end else begin
            v1_r <= cam_vsync;
            h1_r <= cam_href;
            v2_r <= v1_r;
            h2_r <= h1_r;
            d1_r <= cam_data;
        end
    end

    // Next-state, byte assembly and output decode
    always_comb begin
        state_nxt_s       = state_r;
        skip_cnt_nxt_s    = skip_cnt_r;
        phase_nxt_s       = phase_r;
        first_nxt_s       = first_r;
        x_nxt_s           = x_r;
        y_nxt_s           = y_r;
        ovf_nxt_s         = ovf_r;
        rgb_out_nxt_s     = rgb_out_r;
        rgb_valid_nxt_s   = 1'b0;
        pix_x_nxt_s       = pix_x_r;
        pix_y_nxt_s       = pix_y_r;
        frame_start_nxt_s = 1'b0;
        frame_done_nxt_s  = 1'b0;
        line_err_nxt_s    = 1'b0;

        case (state_r)
            ST_SKIP: begin
                // Each vsync fall starts a new frame; the one after the last
                // settle frame is the first one captured
                if (vs_fall_s) begin
                    if (skip_cnt_r == SKIP_LIM) begin
                        state_nxt_s       = ST_ACTIVE;
                        frame_start_nxt_s = 1'b1;
                        phase_nxt_s       = 1'b0;
                        x_nxt_s           = 11'd0;
                        y_nxt_s           = 11'd0;
                        ovf_nxt_s         = 1'b0;
                    end else begin
                        skip_cnt_nxt_s = skip_cnt_r + SKW'(1);
                    end
                end else begin
                    state_nxt_s = ST_SKIP;
                end
            end

            ST_ARMED: begin
                if (vs_fall_s) begin
                    state_nxt_s       = ST_ACTIVE;
                    frame_start_nxt_s = 1'b1;
                    phase_nxt_s       = 1'b0;
                    x_nxt_s           = 11'd0;
                    y_nxt_s           = 11'd0;
                    ovf_nxt_s         = 1'b0;
                end else begin
                    state_nxt_s = ST_ARMED;
                end
            end

            ST_ACTIVE: begin
                if (vs_rise_s) begin
                    // Frame ends; any half pixel in flight is discarded
                    state_nxt_s      = ST_ARMED;
                    frame_done_nxt_s = 1'b1;
                    phase_nxt_s      = 1'b0;
                    x_nxt_s          = 11'd0;
                    ovf_nxt_s        = 1'b0;
                end else if (v1_r) begin
                    state_nxt_s = ST_ACTIVE;
                end else if (h1_r) begin
                    if (!phase_r) begin
                        first_nxt_s = d1_r;
                        phase_nxt_s = 1'b1;
                    end else begin
                        phase_nxt_s = 1'b0;
                        if (y_in_s) begin
                            if (x_r < H_LIM) begin
                                rgb_out_nxt_s   = pixel_s;
                                rgb_valid_nxt_s = 1'b1;
                                pix_x_nxt_s     = x_r;
                                pix_y_nxt_s     = y_r;
                                x_nxt_s         = x_r + 11'd1;
                            end else if (!ovf_r) begin
                                // Overlong line: flag it only once
                                line_err_nxt_s = 1'b1;
                                ovf_nxt_s      = 1'b1;
                            end else begin
                                ovf_nxt_s = 1'b1;
                            end
                        end else begin
                            x_nxt_s = x_r;
                        end
                    end
                end else if (hs_fall_s) begin
                    line_err_nxt_s = phase_r & y_in_s;
                    phase_nxt_s    = 1'b0;
                    x_nxt_s        = 11'd0;
                    ovf_nxt_s      = 1'b0;
                    if (y_in_s) begin
                        y_nxt_s = y_r + 11'd1;
                    end else begin
                        y_nxt_s = y_r;
                    end
                end else begin
                    state_nxt_s = ST_ACTIVE;
                end
            end

            default: begin
                state_nxt_s = ST_INIT;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r       <= ST_INIT;
            skip_cnt_r    <= '0;
            phase_r       <= 1'b0;
            first_r       <= 8'h00;
            x_r           <= 11'd0;
            y_r           <= 11'd0;
            ovf_r         <= 1'b0;
            rgb_out_r     <= 16'h0000;
            rgb_valid_r   <= 1'b0;
            pix_x_r       <= 11'd0;
            pix_y_r       <= 11'd0;
            frame_start_r <= 1'b0;
            frame_done_r  <= 1'b0;
            line_err_r    <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            skip_cnt_r    <= skip_cnt_nxt_s;
            phase_r       <= phase_nxt_s;
            first_r       <= first_nxt_s;
            x_r           <= x_nxt_s;
            y_r           <= y_nxt_s;
            ovf_r         <= ovf_nxt_s;
            rgb_out_r     <= rgb_out_nxt_s;
            rgb_valid_r   <= rgb_valid_nxt_s;
            pix_x_r       <= pix_x_nxt_s;
            pix_y_r       <= pix_y_nxt_s;
            frame_start_r <= frame_start_nxt_s;
            frame_done_r  <= frame_done_nxt_s;
            line_err_r    <= line_err_nxt_s;
        end
    end

endmodule
